// File: rtl/pie_pkg.sv
// pie_pkg: shared state type, default parameters and parity helper for the PIE bit deframer
package pie_pkg;
  typedef enum logic [1:0] {IDLE, HUNT, DATA, PARITY} state_t;
  localparam int PIE_DATA_W = 8;
  localparam int PIE_SYNC_W = 8;
  localparam logic [7:0] PIE_SYNC_PATTERN = 8'hA5;
  localparam int PIE_TIMEOUT_CYC = 200;
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/pie_flag_edge.sv
// pie_flag_edge: rising-edge detect of decoder flags into registered bit events
// ports: sclk_3mhz/reset_n clock and async active-low reset; zero_flag/one_flag decoder symbols;
//        bit_evt one-cycle bit strobe, bit_val its value, conflict both flags rose together
module pie_flag_edge
  import pie_pkg::*;
(
  input  logic sclk_3mhz,
  input  logic reset_n,
  input  logic zero_flag,
  input  logic one_flag,
  output logic bit_evt,
  output logic bit_val,
  output logic conflict
);
  logic zero_q, one_q, rise0, rise1;
  assign rise0 = zero_flag & ~zero_q;
  assign rise1 = one_flag & ~one_q;
  always_ff @(posedge sclk_3mhz or negedge reset_n)
    if (!reset_n) begin
      zero_q   <= 1'b0;
      one_q    <= 1'b0;
      bit_evt  <= 1'b0;
      bit_val  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      zero_q   <= zero_flag;
      one_q    <= one_flag;
      bit_evt  <= rise0 ^ rise1;
      bit_val  <= rise1;
      conflict <= rise0 & rise1;
    end
endmodule

// File: rtl/pie_bit_deframer.sv
// pie_bit_deframer: hunts a sync word in PIE bit events, then captures data + even parity into a valid/ready word
// ports: sclk_3mhz/reset_n clock and async active-low reset; enable (low forces IDLE);
//        zero_flag/one_flag decoded symbols; data_out/data_valid/data_ready output word handshake;
//        sync_locked high in DATA/PARITY; parity/overrun/timeout/symbol_err one-cycle error pulses
module pie_bit_deframer
  import pie_pkg::*;
#(
  parameter int DATA_W = PIE_DATA_W,
  parameter int SYNC_W = PIE_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(PIE_SYNC_PATTERN),
  parameter int TIMEOUT_CYC = PIE_TIMEOUT_CYC
) (
  input  logic              sclk_3mhz,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              zero_flag,
  input  logic              one_flag,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              sync_locked,
  output logic              parity_err,
  output logic              overrun_err,
  output logic              timeout_err,
  output logic              symbol_err
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t            state;
  logic [SYNC_W-1:0] window, win_nx;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bit_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              bit_evt, bit_val, conflict;
  logic              slot_free, par_bad, tmo_hit, last_bit;
  pie_flag_edge u_edge (
    .sclk_3mhz(sclk_3mhz),
    .reset_n  (reset_n),
    .zero_flag(zero_flag),
    .one_flag (one_flag),
    .bit_evt  (bit_evt),
    .bit_val  (bit_val),
    .conflict (conflict)
  );
  assign win_nx    = {window[SYNC_W-2:0], bit_val};
  // a word may load when the slot is empty or is being drained this very cycle
  assign slot_free = !data_valid || data_ready;
  assign par_bad   = even_parity(32'({shift, bit_val}));
  assign tmo_hit   = tmo_cnt == TW'(TIMEOUT_CYC);
  assign last_bit  = bit_cnt == BW'(DATA_W - 1);
  always_ff @(posedge sclk_3mhz or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      window      <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      sync_locked <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
      symbol_err  <= 1'b0;
    end else begin
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
      symbol_err  <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        sync_locked <= 1'b0;
        window      <= '0;
        bit_cnt     <= '0;
        tmo_cnt     <= '0;
      end else if (conflict) begin
        symbol_err  <= 1'b1;
        state       <= HUNT;
        sync_locked <= 1'b0;
        window      <= '0;
      end else begin
        case (state)
          IDLE: state <= HUNT;
          HUNT:
            if (bit_evt) begin
              window <= win_nx;
              if (win_nx == SYNC_PATTERN) begin
                state       <= DATA;
                sync_locked <= 1'b1;
                bit_cnt     <= '0;
                tmo_cnt     <= '0;
              end
            end
          DATA, PARITY:
            if (bit_evt) begin
              tmo_cnt <= '0;
              if (state == DATA) begin
                shift   <= {shift[DATA_W-2:0], bit_val};
                bit_cnt <= bit_cnt + BW'(1);
                if (last_bit) state <= PARITY;
              end else begin
                if (par_bad) parity_err <= 1'b1;
                else if (slot_free) begin
                  data_out   <= shift;
                  data_valid <= 1'b1;
                end else overrun_err <= 1'b1;
                // every frame must re-sync from an empty window
                state       <= HUNT;
                sync_locked <= 1'b0;
                window      <= '0;
              end
            end else if (tmo_hit) begin
              timeout_err <= 1'b1;
              state       <= HUNT;
              sync_locked <= 1'b0;
              window      <= '0;
            end else tmo_cnt <= tmo_cnt + TW'(1);
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: doc/pie_bit_deframer.md
Name: pie_bit_deframer

Overview:
- Sits directly downstream of pulse_interval_decode in the ZCD receive path, in the sclk_3mhz domain.
- Consumes the decoder's zero_flag/one_flag symbol indications and hunts for a sync pattern.
- After sync, assembles DATA_W data bits plus one even-parity bit into a word.
- Presents each word on a valid/ready output with error and status pulses.

Parameters:
- DATA_W, 8, payload bits per frame, MSB first on the wire.
- SYNC_W, 8, sync pattern length in bits.
- SYNC_PATTERN, 8'hA5, sync word that must match before data capture.
- TIMEOUT_CYC, 200, max sclk_3mhz cycles between bits inside a frame; a nominal PIE "1" symbol is about 26 cycles.

Ports:
- sclk_3mhz  in  1  system clock, 3 MHz.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  deframer enable; low forces IDLE.
- zero_flag  in  1  decoded '0' symbol from pulse_interval_decode (level or pulse).
- one_flag  in  1  decoded '1' symbol from pulse_interval_decode (level or pulse).
- data_out  out  DATA_W  received payload word.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts word when data_valid & data_ready.
- sync_locked  out  1  high while in DATA or PARITY.
- parity_err  out  1  one-cycle pulse on a parity failure.
- overrun_err  out  1  one-cycle pulse when a good word is dropped.
- timeout_err  out  1  one-cycle pulse on inter-bit timeout.
- symbol_err  out  1  one-cycle pulse when both flags rise in the same cycle.

Behaviour:
- Reset: all outputs 0; state IDLE; shift, timeout and bit counters 0.
- Reset asserted mid-frame clears everything immediately and drops any held word.
- Symbol events: each flag is rising-edge detected against a registered copy, so a flag held high for many cycles yields exactly one bit.
  - bit_evt = rise0 ^ rise1; bit_val = rise1.
  - rise0 & rise1 in the same cycle: symbol_err pulse next cycle, go to HUNT, clear the sync window.
- States:
  - IDLE: entered when enable=0 from any state (partial frame discarded; a held output word is kept). Go to HUNT when enable=1.
  - HUNT: on bit_evt, window <= {window[SYNC_W-2:0], bit_val}. If the updated window == SYNC_PATTERN, go to DATA; bit_cnt=0, tmo_cnt=0. No timeout in HUNT.
  - DATA: on bit_evt, shift bit into the data shift register, bit_cnt++, tmo_cnt=0. On bit_cnt reaching DATA_W, go to PARITY.
  - PARITY: on bit_evt, check ^{shift_reg, bit_val} == 0 (even parity).
    - Fail: parity_err pulse.
    - Pass, and output slot free or being consumed this cycle: load data_out, data_valid=1.
    - Pass, and slot occupied with data_ready=0: overrun_err pulse; the held data_out is unchanged.
    - In all cases go to HUNT and clear the window, so every frame needs its own sync.
- Timeout (DATA/PARITY only):
  - tmo_cnt increments each cycle without bit_evt.
  - When tmo_cnt == TIMEOUT_CYC: timeout_err pulse, go to HUNT, clear the window.
  - A bit_evt in the same cycle as the limit wins (counter clears, no error).
- Latency: the registered bit event is in cycle N (the cycle after the flag edge appears on the input). data_valid rises at N+1 for the parity bit.
- Output handshake:
  - data_valid clears on data_valid & data_ready unless a new word loads in the same cycle, in which case it stays 1 with the new data.
  - data_out is stable while data_valid & !data_ready.
- sync_locked is a registered decode of the state: 1 in DATA or PARITY.
- Error pulses are registered, last exactly one cycle, and are mutually exclusive per event.
- Widths:
  - bit_cnt is $clog2(DATA_W+1) bits.
  - tmo_cnt is $clog2(TIMEOUT_CYC+1) bits and saturates; it never wraps.

Decomposition:
- pie_pkg holds:
  - state enum {IDLE, HUNT, DATA, PARITY};
  - default constants PIE_DATA_W, PIE_SYNC_W, PIE_SYNC_PATTERN, PIE_TIMEOUT_CYC;
  - the function even_parity().
- Sub-module pie_flag_edge: registers both flags and outputs bit_evt, bit_val and conflict.

Test Plan:
- Sync 0xA5, data 0x3C, parity 0, data_ready=1 -> data_out=0x3C, data_valid for one cycle; no errors; sync_locked high from the sync match until the parity bit.
- Sync 0xA5, data 0x3C, parity 1 -> parity_err one pulse, data_valid stays 0, state returns to HUNT.
- data_ready=0; frame 0x11 then frame 0x22 -> data_out stays 0x11 with data_valid=1, overrun_err pulses once; raising data_ready then drains 0x11 only.
- Sync plus 4 data bits, then 250 idle cycles -> timeout_err at cycle 200 after the last bit; sync_locked=0; a following full frame 0x5A is received correctly.
- zero_flag and one_flag rise in the same cycle during DATA -> symbol_err pulse, HUNT, no data_valid; flags held high for 10 cycles count as a single bit.
- reset_n pulsed low mid-DATA, and enable dropped mid-frame -> all outputs 0 after reset, and the next frame 0xC3 decodes correctly in both cases.
